// File: rtl/mem_io_if.sv
// Request/response handshake bundle between the core and mem_io_ctrl.
interface mem_io_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_sext;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_sext,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory / memory-mapped I/O controller: read-only instruction region, byte-addressable data RAM, I/O channels.
// Define MEM_IO_IRQ_EN to add the io_in change-detect status register and the irq output.
module mem_io_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_BYTES  = 64,
    parameter int unsigned IMEM_BYTES = 32,
    parameter int unsigned IO_BASE    = 128,
    parameter int unsigned IO_CH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_io_if.slave                 bus,
    output logic [IO_CH*DATA_W-1:0] io_out,
    input  logic [IO_CH*DATA_W-1:0] io_in
`ifdef MEM_IO_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int unsigned       MEM_AW   = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] IMEM_LIM = ADDR_W'(IMEM_BYTES);
    localparam logic [ADDR_W-1:0] MEM_LIM  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] IO_LO    = ADDR_W'(IO_BASE);
    localparam logic [1:0]        SZ_B     = 2'b00;
    localparam logic [1:0]        SZ_H     = 2'b01;
    localparam logic [1:0]        SZ_W     = 2'b10;
    localparam logic [1:0]        SZ_BAD   = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_d;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_sext;

    logic [7:0]              mem [MEM_BYTES];
    logic [IO_CH*DATA_W-1:0] io_in_q;

    logic              in_imem, in_dram, in_io, in_stat, misaligned, acc_err;
    logic              ram_we, io_we;
    logic [ADDR_W-1:0] io_off;
    logic [DATA_W-1:0] mem_word, io_rd, load_data, wdata_sh;
    logic [15:0]       mem_sh;
    logic [3:0]        be;

`ifdef MEM_IO_IRQ_EN
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(IO_BASE + 4 * IO_CH);
    logic [IO_CH*DATA_W-1:0] io_prev;
    logic [IO_CH-1:0]        pending, pending_d;
`endif

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_d;
            bus.req_ready <= (state_d == IDLE);
            bus.rsp_valid <= (state_d == RESP);
            if (state == ACCESS) begin
                bus.rsp_rdata <= load_data;
                bus.rsp_err   <= acc_err;
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.req_valid && bus.req_ready) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch on the acceptance edge
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && bus.req_valid && bus.req_ready) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_size  <= bus.req_size;
            r_sext  <= bus.req_sext;
        end
    end

    // Region decode and legality
    always_comb begin
        acc_err    = 1'b1;
        io_off     = r_addr - IO_LO;
        in_imem    = r_addr < IMEM_LIM;
        in_dram    = !in_imem && (r_addr < MEM_LIM);
        in_io      = (r_addr >= IO_LO) && (io_off[1:0] == 2'b00)
                     && (io_off[ADDR_W-1:2] < (ADDR_W-2)'(IO_CH));
`ifdef MEM_IO_IRQ_EN
        in_stat    = (r_addr == STAT_ADDR);
`else
        in_stat    = 1'b0;
`endif
        misaligned = ((r_size == SZ_H) && r_addr[0]) || ((r_size == SZ_W) && (r_addr[1:0] != 2'b00));
        if (r_size == SZ_BAD)      acc_err = 1'b1;
        else if (in_imem)          acc_err = r_we;
        else if (in_dram)          acc_err = misaligned;
        else if (in_io || in_stat) acc_err = (r_size != SZ_W);
    end

    // Load data path; instruction-region loads always return the aligned word
    always_comb begin
        mem_word  = {mem[{r_addr[MEM_AW-1:2], 2'd3}], mem[{r_addr[MEM_AW-1:2], 2'd2}],
                     mem[{r_addr[MEM_AW-1:2], 2'd1}], mem[{r_addr[MEM_AW-1:2], 2'd0}]};
        mem_sh    = 16'(mem_word >> {r_addr[1:0], 3'b000});
        io_rd     = '0;
        load_data = '0;
        for (int k = 0; k < int'(IO_CH); k++) begin
            if (io_off[ADDR_W-1:2] == (ADDR_W-2)'(k)) io_rd = io_in_q[k*DATA_W +: DATA_W];
        end
        if (!acc_err && !r_we) begin
            if (in_imem) begin
                load_data = mem_word;
            end else if (in_dram) begin
                case (r_size)
                    SZ_B:    load_data = {{(DATA_W-8){r_sext & mem_sh[7]}}, mem_sh[7:0]};
                    SZ_H:    load_data = {{(DATA_W-16){r_sext & mem_sh[15]}}, mem_sh};
                    default: load_data = mem_word;
                endcase
            end else if (in_io) begin
                load_data = io_rd;
            end
`ifdef MEM_IO_IRQ_EN
            if (in_stat) load_data = DATA_W'(pending);
`endif
        end
    end

    always_comb begin
        ram_we   = (state == ACCESS) && !acc_err && r_we && in_dram;
        io_we    = (state == ACCESS) && !acc_err && r_we && in_io;
        wdata_sh = r_wdata << {r_addr[1:0], 3'b000};
        be       = 4'b1111;
        case (r_size)
            SZ_B:    be = 4'b0001 << r_addr[1:0];
            SZ_H:    be = 4'b0011 << r_addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    // Data RAM byte lanes; no reset on the array
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            if (be[0]) mem[{r_addr[MEM_AW-1:2], 2'd0}] <= wdata_sh[7:0];
            if (be[1]) mem[{r_addr[MEM_AW-1:2], 2'd1}] <= wdata_sh[15:8];
            if (be[2]) mem[{r_addr[MEM_AW-1:2], 2'd2}] <= wdata_sh[23:16];
            if (be[3]) mem[{r_addr[MEM_AW-1:2], 2'd3}] <= wdata_sh[31:24];
        end
    end

    always_ff @(posedge clk) begin
        io_in_q <= io_in;
        if (rst) begin
            io_out <= '0;
        end else if (io_we) begin
            for (int k = 0; k < int'(IO_CH); k++) begin
                if (io_off[ADDR_W-1:2] == (ADDR_W-2)'(k)) io_out[k*DATA_W +: DATA_W] <= r_wdata;
            end
        end
    end

`ifdef MEM_IO_IRQ_EN
    // Pending flags: write-1-to-clear, a same-cycle change on the channel wins
    always_comb begin
        pending_d = pending;
        if ((state == ACCESS) && !acc_err && r_we && in_stat) pending_d = pending_d & ~r_wdata[IO_CH-1:0];
        for (int k = 0; k < int'(IO_CH); k++) begin
            if (io_in_q[k*DATA_W +: DATA_W] != io_prev[k*DATA_W +: DATA_W]) pending_d[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        io_prev <= io_in_q;
        if (rst) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_d;
            irq     <= |pending_d;
        end
    end
`endif
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: vector table through a scoreboard plus multi-cycle corner sequences.
module tb_mem_io_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IO_CH  = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk;
        logic [31:0] addr;
        longint      t;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [IO_CH*DATA_W-1:0] io_out;
    logic [IO_CH*DATA_W-1:0] io_in = '0;
`ifdef MEM_IO_IRQ_EN
    logic                    irq;
`endif
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] last_rdata = '0;

    mem_io_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_io_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(64), .IMEM_BYTES(32),
        .IO_BASE(128), .IO_CH(IO_CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .io_out(io_out),
        .io_in(io_in)
`ifdef MEM_IO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("rsp_err@%08h", e.addr), 32'(bus.rsp_err), 32'(e.err));
                if (e.chk) check($sformatf("rsp_rdata@%08h", e.addr), bus.rsp_rdata, e.rd);
                else last_rdata = bus.rsp_rdata;
                check($sformatf("rsp_latency@%08h", e.addr), 32'($time), 32'(e.t));
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext, input logic [31:0] rd,
                          input logic err, input logic chk, input logic push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        if (bus.req_ready !== 1'b1) return;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_size  = size;
        bus.req_sext  = sext;
        @(posedge clk);
        if (push) begin
            e.rd = rd; e.err = err; e.chk = chk; e.addr = addr;
            e.t  = longint'($time) + 15;
            sb_q.push_back(e);
        end
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_rsp_missing", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] w0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_size = 2'b00; bus.req_sext = 1'b0;
        io_in[63:32]  = 32'h0000_00A5;

        //               we    addr          wdata         size   sext  rdata         err
        tbl.push_back('{1'b1, 32'h20,       32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h23,       32'h0,        2'b00, 1'b1, 32'hFFFFFFDE, 1'b0});
        tbl.push_back('{1'b0, 32'h23,       32'h0,        2'b00, 1'b0, 32'h000000DE, 1'b0});
        tbl.push_back('{1'b0, 32'h22,       32'h0,        2'b01, 1'b1, 32'hFFFFDEAD, 1'b0});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        2'b01, 1'b0, 32'h0000BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0});
        tbl.push_back('{1'b1, 32'h21,       32'h00000055, 2'b00, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h21,       32'h11111111, 2'b10, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h23,       32'h22222222, 2'b01, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h20,       32'h33333333, 2'b11, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        2'b10, 1'b0, 32'hDEAD55EF, 1'b0});
        tbl.push_back('{1'b1, 32'h24,       32'hAABBCCDD, 2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h26,       32'h00001234, 2'b01, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h24,       32'h0,        2'b10, 1'b0, 32'h1234CCDD, 1'b0});
        tbl.push_back('{1'b0, 32'h25,       32'h0,        2'b00, 1'b1, 32'hFFFFFFCC, 1'b0});
        tbl.push_back('{1'b0, 32'h26,       32'h0,        2'b01, 1'b1, 32'h00001234, 1'b0});
        tbl.push_back('{1'b0, 32'h21,       32'h0,        2'b01, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h40,       32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h20,       32'h0,        2'b11, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h22,       32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h04,       32'h0,        2'b11, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h07,       32'h000000FF, 2'b00, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h3C,       32'h01020304, 2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h3F,       32'h0,        2'b00, 1'b0, 32'h00000001, 1'b0});
        tbl.push_back('{1'b0, 32'h3C,       32'h0,        2'b10, 1'b0, 32'h01020304, 1'b0});
        tbl.push_back('{1'b1, 32'h88,       32'h12345678, 2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h80,       32'h0BADF00D, 2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h80,       32'h000000FF, 2'b00, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h82,       32'hFFFFFFFF, 2'b10, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h84,       32'h0,        2'b10, 1'b0, 32'h000000A5, 1'b0});
        tbl.push_back('{1'b0, 32'h8C,       32'h0,        2'b10, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h84,       32'h0,        2'b00, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h7C,       32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'hFFFFFFF0, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
`ifndef MEM_IO_IRQ_EN
        tbl.push_back('{1'b0, 32'h90,       32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata,      32'd0);
        check("reset_io_out",    32'(io_out != '0),  32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].sext,
                   tbl[i].rd, tbl[i].err, 1'b1, 1'b1);
        end
        drain();

        check("io_out_ch0", io_out[31:0],   32'h0BADF00D);
        check("io_out_ch1", io_out[63:32],  32'h0);
        check("io_out_ch2", io_out[95:64],  32'h12345678);
        check("io_out_ch3", io_out[127:96], 32'h0);

        // io_out changes on the edge ending ACCESS
        do_req(1'b1, 32'h84, 32'h00000077, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("io_out_ch1_during_access", io_out[63:32], 32'h0);
        @(negedge clk);
        check("io_out_ch1_after_access", io_out[63:32], 32'h00000077);
        drain();

        // Instruction region: stores rejected, sub-word loads return the whole word
        do_req(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        w0 = last_rdata;
        do_req(1'b1, 32'h04, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        do_req(1'b0, 32'h04, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        check("imem_word_unchanged", last_rdata, w0);
        do_req(1'b0, 32'h05, 32'h0, 2'b00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();
        check("imem_byte_load_is_word", last_rdata, w0);

        // Reset during ACCESS of a RAM store: no write, no response
        do_req(1'b1, 32'h20, 32'h99999999, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_io_out",    32'(io_out != '0),  32'd0);
        rst = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hDEAD55EF, 1'b0, 1'b1, 1'b1);
        drain();

`ifdef MEM_IO_IRQ_EN
        do_req(1'b1, 32'h90, 32'h0000000F, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        io_in[127:96] = 32'h00000001;
        repeat (4) @(negedge clk);
        check("irq_after_toggle", 32'(irq), 32'd1);
        do_req(1'b0, 32'h90, 32'h0, 2'b10, 1'b0, 32'h00000008, 1'b0, 1'b1, 1'b1);
        do_req(1'b1, 32'h90, 32'h000000FF, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        drain();
        check("irq_after_byte_store", 32'(irq), 32'd1);
        do_req(1'b1, 32'h90, 32'h00000008, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drain();
        check("irq_after_w1c", 32'(irq), 32'd0);
        do_req(1'b0, 32'h90, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
